// File: rtl/interp_out_fifo_pkg.sv
// rtl/interp_out_fifo_pkg.sv - shared constants for the interpolator output path
//
// Purpose : holds the default sample width so the interpolator and its
//           output FIFO agree on the sample word size.
// Ports   : none (package).

package interp_out_fifo_pkg;

    // Default interpolator sample width (interpolator INW).
    localparam int INTERP_DW = 28;

endpackage : interp_out_fifo_pkg

// File: rtl/sfifo_mem.sv
// rtl/sfifo_mem.sv - simple dual-port RAM with registered read for the output FIFO
//
// Purpose : storage array for interp_out_fifo, kept separate so it maps onto
//           block or distributed RAM. One write port, one read port, the read
//           data is registered (read-before-write on an address collision).
// Ports   :
//   i_clk    - clock, rising edge
//   i_we     - write enable
//   i_waddr  - write address
//   i_wdata  - write data
//   i_raddr  - read address, sampled every rising edge
//   o_rdata  - registered read data (contents of i_raddr at the last edge)

module sfifo_mem #(
    parameter int DW = 28,
    parameter int AW = 4
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    // Storage is intentionally not reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
        rdata_q <= mem[i_raddr];
    end

    assign o_rdata = rdata_q;

endmodule : sfifo_mem

// File: rtl/interp_out_fifo.sv
// rtl/interp_out_fifo.sv - first-word-fall-through FIFO behind the interpolator
//
// Purpose : captures interpolator samples on i_ce and presents them on a
//           valid/ready stream with a registered head word (o_data), reporting
//           fill level, sticky overflow and a saturating drop count.
// Ports   :
//   i_clk, i_reset_n  - clock and synchronous active-low reset
//   i_ce, i_data      - write strobe and sample from the interpolator
//   o_valid, i_ready  - output handshake; o_data is the head sample
//   o_fill, o_full    - entries held (head included), full flag
//   o_overflow        - sticky drop flag
//   i_clr_overflow    - clears o_overflow and o_drops
//   o_drops           - saturating count of dropped writes

module interp_out_fifo
    import interp_out_fifo_pkg::*;
#(
    parameter int DW     = INTERP_DW,
    parameter int LGFLEN = 4,
    parameter int DROPW  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_ce,
    input  logic [DW-1:0]     i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DW-1:0]     o_data,
    output logic [LGFLEN:0]   o_fill,
    output logic              o_full,
    output logic              o_overflow,
    input  logic              i_clr_overflow,
    output logic [DROPW-1:0]  o_drops
);

    localparam int              DEPTH     = 1 << LGFLEN;
    localparam logic [LGFLEN:0] FULL_CNT  = (LGFLEN+1)'(DEPTH);
    localparam logic [LGFLEN:0] ONE_CNT   = (LGFLEN+1)'(1);
    localparam logic [DROPW-1:0] DROP_MAX = '1;

    logic [LGFLEN-1:0] wr_ptr_q, wr_ptr_d;
    logic [LGFLEN-1:0] rd_ptr_q, rd_ptr_d;
    logic [LGFLEN:0]   fill_q, fill_d;
    logic              full_q, full_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic [DROPW-1:0]  drops_q, drops_d;
    logic [DW-1:0]     data_q, data_d;
    logic [DW-1:0]     byp_q, byp_d;
    logic              stale_q, stale_d;

    logic              rd, wr, drop;
    logic [LGFLEN-1:0] next_addr;
    logic [LGFLEN-1:0] ram_raddr;
    logic [DW-1:0]     ram_rdata;

    // The RAM always prefetches the entry behind the head, so it is ready
    // the moment the head is consumed.
    assign next_addr = rd_ptr_d + LGFLEN'(1);
    assign ram_raddr = i_reset_n ? next_addr : LGFLEN'(1);

    sfifo_mem #(
        .DW (DW),
        .AW (LGFLEN)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (wr & i_reset_n),
        .i_waddr (wr_ptr_q),
        .i_wdata (i_data),
        .i_raddr (ram_raddr),
        .o_rdata (ram_rdata)
    );

    always_comb begin
        rd   = valid_q & i_ready;
        wr   = i_ce & (~full_q | rd);
        drop = i_ce & full_q & ~rd;

        wr_ptr_d = wr_ptr_q + LGFLEN'(wr);
        rd_ptr_d = rd_ptr_q + LGFLEN'(rd);
        fill_d   = fill_q + (LGFLEN+1)'(wr) - (LGFLEN+1)'(rd);
        full_d   = (fill_d == FULL_CNT);
        valid_d  = (fill_d != '0);

        // A write landing on the prefetch address this edge makes the RAM
        // output stale (read-before-write); remember the written word instead.
        stale_d = wr & (wr_ptr_q == next_addr);
        byp_d   = wr ? i_data : byp_q;

        data_d = data_q;
        if (rd) begin
            if (fill_q > ONE_CNT) begin
                data_d = stale_q ? byp_q : ram_rdata;
            end else if (wr) begin
                data_d = i_data;
            end
        end else if (!valid_q && wr) begin
            data_d = i_data;
        end

        ovf_d   = ovf_q & ~i_clr_overflow;
        drops_d = i_clr_overflow ? '0 : drops_q;
        if (drop) begin
            ovf_d = 1'b1;
            if (i_clr_overflow) begin
                drops_d = DROPW'(1);
            end else if (drops_q != DROP_MAX) begin
                drops_d = drops_q + DROPW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            full_q   <= 1'b0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            drops_q  <= '0;
            data_q   <= '0;
            byp_q    <= '0;
            stale_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            full_q   <= full_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            drops_q  <= drops_d;
            data_q   <= data_d;
            byp_q    <= byp_d;
            stale_q  <= stale_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_fill     = fill_q;
    assign o_full     = full_q;
    assign o_overflow = ovf_q;
    assign o_drops    = drops_q;

endmodule : interp_out_fifo

// File: doc/interp_out_fifo.md
Name: interp_out_fifo

Overview:
- Downstream stage of the nearest-neighbour interpolator.
- Absorbs its output-rate clock-enable pulse (o_ce) and sample word (o_data) and buffers them in a synchronous FIFO.
- Presents the samples to the rest of the design on a valid/ready stream, which decouples the bursty interpolator output from a back-pressuring consumer.
- Reports fill level, overflow and a saturating count of dropped samples.

Parameters:
- DW, 28, sample width; matches interpolator INW.
- LGFLEN, 4, log2 of FIFO depth; depth = 2^LGFLEN entries, LGFLEN >= 1.
- DROPW, 16, width of dropped-sample counter.

Ports:
- i_clk  in  1  sole clock; all logic on rising edge.
- i_reset_n  in  1  synchronous, active-low reset.
- i_ce  in  1  write strobe; driven by the interpolator's o_ce.
- i_data  in  DW  sample; driven by the interpolator's o_data, captured when i_ce=1.
- o_valid  out  1  output sample available.
- i_ready  in  1  consumer accepts o_data this cycle when o_valid=1.
- o_data  out  DW  head-of-FIFO sample.
- o_fill  out  LGFLEN+1  number of entries held, including the one on o_data.
- o_full  out  1  o_fill == 2^LGFLEN.
- o_overflow  out  1  sticky: a write was dropped.
- i_clr_overflow  in  1  clears o_overflow and the drop counter.
- o_drops  out  DROPW  saturating count of dropped writes.

Behaviour:
- Reset (i_reset_n=0 at a clock edge), same edge:
  - pointers = 0, o_fill = 0, o_valid = 0, o_full = 0, o_overflow = 0, o_drops = 0, o_data = 0.
  - FIFO storage is not cleared.
  - Reset overrides every other input that cycle.
  - Reset mid-burst discards all contents.
- Definitions: rd = o_valid & i_ready; wr = i_ce & (~o_full | rd).
- Write acceptance: with i_ce=1 and o_full=1, a same-cycle read frees a slot, so the write is accepted.
  - Fill stays at full.
  - Nothing is dropped.
- Drop: i_ce & o_full & ~rd.
  - Sample is discarded and FIFO contents are unchanged.
  - o_overflow <= 1.
  - o_drops increments, saturating at 2^DROPW-1.
- Overflow clear: i_clr_overflow=1 clears o_overflow and o_drops next edge.
  - A drop in the same cycle wins: o_overflow = 1, o_drops = 1.
- Fill update:
  - o_fill <= o_fill + wr - rd, registered.
  - o_full and o_valid (o_fill != 0) are registered alongside o_fill, not decoded combinationally.
- Latency, first-word-fall-through:
  - Write into an empty FIFO at edge N gives o_valid=1 and o_data=sample after edge N.
  - Zero added bubble.
  - o_data is a register, loaded from the write path when the FIFO is empty or about to empty, otherwise from storage.
- Stream stability: while o_valid=1 and i_ready=0, o_data and o_valid must not change.
- Simultaneous read/write with fill=1: o_data updates to the new sample, o_valid stays 1, fill stays 1.
- Pointers: LGFLEN bits, wrap naturally modulo depth; no explicit wrap logic.
- No combinational path from i_ready to o_valid or o_data.
- Throughput: one write and one read per cycle sustained indefinitely.

Decomposition:
- Shared package: none required.
  - Fill/pointer widths are derived locally from LGFLEN.
  - If the team package exists, put the default sample width constant (28) there so the interpolator and this block agree.
- Sub-module: sfifo_mem, a simple dual-port RAM with registered read, DW x 2^LGFLEN.
  - Isolates storage so it infers block/distributed RAM.
  - The FWFT output register and control stay in interp_out_fifo.

Test Plan:
- Reset then single write: i_ce=1, i_data=0x0000123 at edge 1, i_ready=0 → after edge 1 o_valid=1, o_data=0x0000123, o_fill=1; stays stable for 10 cycles.
- Fill to full, LGFLEN=4: 16 writes of 1..16, i_ready=0 → o_full=1, o_fill=16; one more write (17) → o_overflow=1, o_drops=1; then drain with i_ready=1 → reads 1..16 in order, never 17.
- Full with simultaneous read/write: at o_fill=16 assert i_ce and i_ready together → o_fill stays 16, o_overflow stays 0, and the written sample appears as the 17th read.
- Interpolator-rate stream: i_ce every 3rd cycle, i_ready random 50% → output sequence equals input sequence, no drops, o_fill <= 16.
- Drop counter: DROPW=2, hold full and issue 5 dropped writes → o_drops=3 (saturated); pulse i_clr_overflow → o_overflow=0, o_drops=0; clear with simultaneous drop → o_drops=1, o_overflow=1.
- Reset mid-operation: o_fill=7, assert i_reset_n=0 for one cycle while i_ce=1 → o_fill=0, o_valid=0, o_overflow=0; the next write appears alone at the output.
